conv3d_filter_sequencer: RTL

//  Time-multiplexes one conv3d_kernel_*_channel_size_3 datapath over all output filters of a layer.
//  For each filter f it:
//   - loads that filter's CHANNEL*9 weights plus its bias from weight memory into the kernel's weight registers;
//   - streams the IMG_WIDTH*IMG_HEIGHT input pixels;
//   - waits for the kernel's done pulse.

---
 rtl/conv3d_filter_sequencer_if.sv | 29 ++
 rtl/conv3d_filter_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/conv3d_filter_sequencer_if.sv
// Bus between the filter sequencer and its kernel-side resources:
// the weight memory read port, the kernel weight-load port, the pixel
// memory read port with its valid strobe, and the kernel done pulse.
interface conv3d_filter_sequencer_if;
  logic        w_rd_en;
  logic [31:0] w_rd_addr;
  logic [31:0] w_rd_data;
  logic        w_load;
  logic [15:0] w_load_idx;
  logic [31:0] w_load_data;
  logic        px_rd_en;
  logic [31:0] px_rd_addr;
  logic        px_valid;
  logic        k_done;

  // Sequencer side
  modport master (
    output w_rd_en, w_rd_addr, w_load, w_load_idx, w_load_data,
    output px_rd_en, px_rd_addr, px_valid,
    input  w_rd_data, k_done
  );

  // Memories / kernel side
  modport slave (
    input  w_rd_en, w_rd_addr, w_load, w_load_idx, w_load_data,
    input  px_rd_en, px_rd_addr, px_valid,
    output w_rd_data, k_done
  );
endinterface

// File: rtl/conv3d_filter_sequencer.sv
// Time-multiplexes one 3x3 convolution kernel over all filters of a layer:
// per filter it loads CHANNEL*9 weights plus bias, streams every pixel of
// the feature map, then waits for the kernel's done pulse (with watchdog).
module conv3d_filter_sequencer #(
  parameter int unsigned CHANNEL    = 3,
  parameter int unsigned N_FILTER   = 64,
  parameter int unsigned IMG_WIDTH  = 56,
  parameter int unsigned IMG_HEIGHT = 56,
  parameter int unsigned TIMEOUT    = 8192
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        hold,
  output logic        busy,
  output logic        layer_done,
  output logic        error,
  output logic [15:0] filter_idx,
  conv3d_filter_sequencer_if.master bus
);

  // Weights per filter (incl. bias) and pixels per feature map
  localparam logic [31:0] WPF       = 32'(CHANNEL * 9 + 1);
  localparam logic [31:0] LAST_PIX  = 32'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [15:0] LAST_K    = 16'(CHANNEL * 9);
  localparam logic [15:0] LAST_F    = 16'(N_FILTER - 1);
  localparam logic [31:0] LAST_WDOG = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_WAIT_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] filter_idx_reg;
  logic [31:0] base_reg;        // filter_idx * WPF, built by accumulation
  logic [15:0] k_reg;           // weight index within current filter
  logic [31:0] p_reg;           // pixel index within current map
  logic [31:0] wdog_reg;        // cycles spent in DRAIN
  logic        error_reg;
  logic        w_load_reg;
  logic [15:0] w_load_idx_reg;
  logic        px_valid_reg;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic; k_done outside DRAIN and start outside IDLE are ignored
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_LOAD_W;
      S_LOAD_W: if (k_reg == LAST_K) state_next = S_WAIT_W;
      S_WAIT_W: state_next = S_STREAM;
      S_STREAM: if (!hold && p_reg == LAST_PIX) state_next = S_DRAIN;
      S_DRAIN: begin
        if (bus.k_done)
          state_next = (filter_idx_reg == LAST_F) ? S_DONE : S_LOAD_W;
        else if (wdog_reg == LAST_WDOG)
          state_next = S_IDLE;
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; addresses are forced to 0 outside their phases
  always_comb begin
    busy           = (state_reg != S_IDLE);
    layer_done     = (state_reg == S_DONE);
    bus.w_rd_en    = 1'b0;
    bus.w_rd_addr  = 32'd0;
    bus.px_rd_en   = 1'b0;
    bus.px_rd_addr = 32'd0;
    case (state_reg)
      S_LOAD_W: begin
        bus.w_rd_en   = 1'b1;
        bus.w_rd_addr = base_reg + {16'd0, k_reg};
      end
      S_STREAM: begin
        bus.px_rd_en   = !hold;
        bus.px_rd_addr = p_reg;
      end
      default: ;
    endcase
  end

  // Counters, filter bookkeeping, watchdog and sticky error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filter_idx_reg <= 16'd0;
      base_reg       <= 32'd0;
      k_reg          <= 16'd0;
      p_reg          <= 32'd0;
      wdog_reg       <= 32'd0;
      error_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          wdog_reg <= 32'd0;
          if (start) begin
            filter_idx_reg <= 16'd0;
            base_reg       <= 32'd0;
            k_reg          <= 16'd0;
            p_reg          <= 32'd0;
            error_reg      <= 1'b0;
          end
        end
        S_LOAD_W: k_reg <= (k_reg == LAST_K) ? 16'd0 : k_reg + 16'd1;
        S_STREAM: if (!hold) p_reg <= (p_reg == LAST_PIX) ? 32'd0 : p_reg + 32'd1;
        S_DRAIN: begin
          if (bus.k_done) begin
            wdog_reg <= 32'd0;
            if (filter_idx_reg != LAST_F) begin
              filter_idx_reg <= filter_idx_reg + 16'd1;
              base_reg       <= base_reg + WPF;
            end
          end else if (wdog_reg == LAST_WDOG) begin
            wdog_reg  <= 32'd0;
            error_reg <= 1'b1;
          end else begin
            wdog_reg <= wdog_reg + 32'd1;
          end
        end
        default: wdog_reg <= 32'd0;
      endcase
    end
  end

  // One-cycle delay of read strobes to line up with memory read latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_load_reg     <= 1'b0;
      w_load_idx_reg <= 16'd0;
      px_valid_reg   <= 1'b0;
    end else begin
      w_load_reg   <= bus.w_rd_en;
      px_valid_reg <= bus.px_rd_en;
      if (bus.w_rd_en) w_load_idx_reg <= k_reg;
    end
  end

  // The weight memory's output register supplies the data register for the
  // load strobe; gating keeps w_load_data at 0 whenever no load is pending.
  assign bus.w_load      = w_load_reg;
  assign bus.w_load_idx  = w_load_idx_reg;
  assign bus.w_load_data = w_load_reg ? bus.w_rd_data : 32'd0;
  assign bus.px_valid    = px_valid_reg;
  assign error           = error_reg;
  assign filter_idx      = filter_idx_reg;

endmodule
